// File: rtl/instr_encoder_loader.sv
// instr_encoder_loader: encodes RV32I operation descriptors and streams them into instruction memory
module instr_encoder_loader #(
  parameter int DEPTH = 256,
  parameter int ADDR_W = 10,
  parameter int BASE_ADDR = 0
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       start,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic                       in_last,
  input  logic [2:0]                 op_class,
  input  logic [3:0]                 ctrl_op,
  input  logic [4:0]                 rd,
  input  logic [4:0]                 rs1,
  input  logic [4:0]                 rs2,
  input  logic [12:0]                imm,
  output logic                       imem_we,
  output logic [ADDR_W-1:0]          imem_addr,
  output logic [31:0]                imem_wdata,
  output logic [$clog2(DEPTH+1)-1:0] word_count,
  output logic                       done,
  output logic                       err
);
  localparam int CW = $clog2(DEPTH+1);
  typedef enum logic [1:0] {IDLE, LOAD, FLUSH, DONE} state_t;
  state_t state;
  logic [2:0] f3;
  logic [31:0] enc;
  logic alt, shift, legal, accept, wr;
  assign in_ready = (state == LOAD) && (word_count < CW'(DEPTH)) && !start;
  assign accept = in_valid && in_ready;
  assign alt = (ctrl_op == 4'd1) || (ctrl_op == 4'd7);
  assign shift = (ctrl_op == 4'd5) || (ctrl_op == 4'd6) || (ctrl_op == 4'd7);
  assign legal = (op_class <= 3'd4) && (ctrl_op <= 4'd9) &&
                 !(op_class == 3'd1 && ctrl_op == 4'd1) &&
                 !(op_class == 3'd4 && imm[0]) &&
                 !(op_class >= 3'd2 && ctrl_op != 4'd0);
  assign wr = accept && legal;
  always_comb begin
    f3 = 3'd0;
    case (ctrl_op)
      4'd2: f3 = 3'd4;
      4'd3: f3 = 3'd6;
      4'd4: f3 = 3'd7;
      4'd5: f3 = 3'd1;
      4'd6, 4'd7: f3 = 3'd5;
      4'd8: f3 = 3'd2;
      4'd9: f3 = 3'd3;
      default: f3 = 3'd0;
    endcase
  end
  always_comb begin
    enc = '0;
    case (op_class)
      3'd0: enc = {1'b0, alt, 5'b0, rs2, rs1, f3, rd, 7'b0110011};
      3'd1: enc = shift ? {1'b0, alt, 5'b0, imm[4:0], rs1, f3, rd, 7'b0010011}
                        : {imm[11:0], rs1, f3, rd, 7'b0010011};
      3'd2: enc = {imm[11:0], rs1, 3'b010, rd, 7'b0000011};
      3'd3: enc = {imm[11:5], rs2, rs1, 3'b010, imm[4:0], 7'b0100011};
      3'd4: enc = {imm[12], imm[10:5], rs2, rs1, 3'b000, imm[4:1], imm[11], 7'b1100011};
      default: enc = '0;
    endcase
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      imem_we <= 1'b0;
      imem_addr <= ADDR_W'(BASE_ADDR);
      imem_wdata <= '0;
      word_count <= '0;
      done <= 1'b0;
      err <= 1'b0;
    end else if (start) begin
      state <= LOAD;
      imem_we <= 1'b0;
      word_count <= '0;
      done <= 1'b0;
      err <= 1'b0;
    end else begin
      imem_we <= wr;
      if (wr) begin
        imem_addr <= ADDR_W'(BASE_ADDR + 4 * int'(word_count));
        imem_wdata <= enc;
        word_count <= word_count + 1'b1;
      end
      if (accept && !legal)
        err <= 1'b1;
      case (state)
        LOAD: if ((accept && in_last) || (wr && word_count == CW'(DEPTH - 1)) || word_count == CW'(DEPTH))
          state <= FLUSH;
        FLUSH: begin
          state <= DONE;
          done <= 1'b1;
        end
        default: state <= state;
      endcase
    end
  end
endmodule

// File: tb/tb_instr_encoder_loader.sv
// tb_instr_encoder_loader: directed and random checks of the encoder/loader against a behavioural model
module tb_instr_encoder_loader;
  logic clk = 1'b0, rst = 1'b1, start = 1'b0, in_valid = 1'b0, in_last = 1'b0;
  logic [2:0] op_class = '0;
  logic [3:0] ctrl_op = '0;
  logic [4:0] rd = '0, rs1 = '0, rs2 = '0;
  logic [12:0] imm = '0;
  logic in_ready, imem_we, done, err;
  logic [9:0] imem_addr;
  logic [31:0] imem_wdata;
  logic [8:0] word_count;
  logic start_s = 1'b0, valid_s = 1'b0;
  logic ready_s, we_s, done_s, err_s;
  logic [9:0] addr_s;
  logic [31:0] wdata_s;
  logic [2:0] count_s;
  int nchk = 0, nfail = 0;
  int m_state = 0, m_count = 0, m_err = 0;

  always #5 clk = ~clk;

  instr_encoder_loader dut (
    .clk(clk), .rst(rst), .start(start), .in_valid(in_valid), .in_ready(in_ready), .in_last(in_last),
    .op_class(op_class), .ctrl_op(ctrl_op), .rd(rd), .rs1(rs1), .rs2(rs2), .imm(imm),
    .imem_we(imem_we), .imem_addr(imem_addr), .imem_wdata(imem_wdata), .word_count(word_count),
    .done(done), .err(err)
  );

  instr_encoder_loader #(.DEPTH(4)) dut_s (
    .clk(clk), .rst(rst), .start(start_s), .in_valid(valid_s), .in_ready(ready_s), .in_last(in_last),
    .op_class(op_class), .ctrl_op(ctrl_op), .rd(rd), .rs1(rs1), .rs2(rs2), .imm(imm),
    .imem_we(we_s), .imem_addr(addr_s), .imem_wdata(wdata_s), .word_count(count_s),
    .done(done_s), .err(err_s)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nchk++;
    assert (obs === exp) else begin
      nfail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic bit ref_legal(int cls, int op, int im);
    if (cls > 4 || op > 9) return 0;
    if (cls == 1 && op == 1) return 0;
    if (cls == 4 && im % 2 == 1) return 0;
    if (cls >= 2 && op != 0) return 0;
    return 1;
  endfunction

  function automatic logic [31:0] ref_enc(int cls, int op, int d, int s1, int s2, int im);
    int f3tab[10] = '{0, 0, 4, 6, 7, 1, 5, 5, 2, 3};
    longint unsigned w, f3, f7;
    f3 = f3tab[op];
    f7 = (op == 1 || op == 7) ? 32 : 0;
    case (cls)
      0: w = 'h33 + d * 2**7 + f3 * 2**12 + s1 * 2**15 + s2 * 2**20 + f7 * 2**25;
      1: w = (op >= 5 && op <= 7) ? 'h13 + d * 2**7 + f3 * 2**12 + s1 * 2**15 + (im % 32) * 2**20 + f7 * 2**25
                                  : 'h13 + d * 2**7 + f3 * 2**12 + s1 * 2**15 + (im % 4096) * 2**20;
      2: w = 'h03 + d * 2**7 + 2 * 2**12 + s1 * 2**15 + (im % 4096) * 2**20;
      3: w = 'h23 + (im % 32) * 2**7 + 2 * 2**12 + s1 * 2**15 + s2 * 2**20 + ((im / 32) % 128) * 2**25;
      default: w = 'h63 + ((im / 2048) % 2) * 2**7 + ((im / 2) % 16) * 2**8 + s1 * 2**15 + s2 * 2**20 +
                   ((im / 32) % 64) * 2**25 + ((im / 4096) % 2) * 2**31;
    endcase
    return w[31:0];
  endfunction

  task automatic model_step(input bit acc, input bit lg, input bit last);
    if (m_state == 1 && acc) begin
      if (lg) m_count++;
      else m_err = 1;
      if (last || m_count == 256) m_state = 2;
    end else if (m_state == 2) m_state = 3;
  endtask

  task automatic check_status(input string tag);
    check({tag, ".count"}, 32'(word_count), 32'(m_count));
    check({tag, ".err"}, 32'(err), 32'(m_err));
    check({tag, ".done"}, 32'(done), 32'(m_state == 3));
  endtask

  task automatic send(input bit v, input bit last, input int cls, input int op,
                      input int d, input int s1, input int s2, input int im);
    bit rdy, lg;
    int pre;
    in_valid = v; in_last = last; op_class = 3'(cls); ctrl_op = 4'(op);
    rd = 5'(d); rs1 = 5'(s1); rs2 = 5'(s2); imm = 13'(im);
    #1;
    rdy = (m_state == 1) && (m_count < 256);
    check("in_ready", 32'(in_ready), 32'(rdy));
    lg = ref_legal(cls, op, im);
    pre = m_count;
    tick();
    model_step(v && rdy, lg, last);
    check("imem_we", 32'(imem_we), 32'(v && rdy && lg));
    if (v && rdy && lg) begin
      check("imem_addr", 32'(imem_addr), 32'(4 * pre));
      check("imem_wdata", imem_wdata, ref_enc(cls, op, d, s1, s2, im));
    end
    check_status("send");
    in_valid = 1'b0; in_last = 1'b0;
  endtask

  task automatic idle();
    in_valid = 1'b0;
    tick();
    model_step(0, 0, 0);
    check("idle.we", 32'(imem_we), 0);
    check_status("idle");
  endtask

  task automatic do_start();
    start = 1'b1; in_valid = 1'b1;
    #1;
    check("start.ready", 32'(in_ready), 0);
    tick();
    start = 1'b0; in_valid = 1'b0;
    m_state = 1; m_count = 0; m_err = 0;
    check("start.we", 32'(imem_we), 0);
    check_status("start");
  endtask

  initial begin
    tick(); tick();
    check("rst.we", 32'(imem_we), 0);
    check("rst.addr", 32'(imem_addr), 0);
    check("rst.wdata", imem_wdata, 0);
    check("rst.ready", 32'(in_ready), 0);
    check_status("rst");
    rst = 1'b0;
    send(1, 0, 0, 0, 3, 1, 2, 0);
    do_start();
    send(1, 0, 0, 0, 3, 1, 2, 0);
    check("radd.wdata", imem_wdata, 32'h002081B3);
    check("radd.count", 32'(word_count), 1);
    do_start();
    send(1, 0, 1, 0, 5, 0, 0, 'hFFF);
    check("iadd.wdata", imem_wdata, 32'hFFF00293);
    send(1, 0, 1, 7, 1, 1, 0, 3);
    check("isra.wdata", imem_wdata, 32'h4030D093);
    check("isra.addr", 32'(imem_addr), 32'h4);
    send(1, 0, 3, 0, 0, 1, 2, 8);
    check("sw.wdata", imem_wdata, 32'h0020A423);
    send(1, 1, 4, 0, 0, 1, 2, 'h1FFC);
    check("beq.wdata", imem_wdata, 32'hFE208EE3);
    idle();
    idle();
    check("beq.done", 32'(done), 1);
    send(1, 0, 0, 0, 1, 1, 1, 0);
    do_start();
    send(1, 0, 1, 1, 4, 2, 0, 5);
    check("ill.err", 32'(err), 1);
    send(1, 0, 2, 0, 7, 3, 0, 'h40);
    check("ill.next_addr", 32'(imem_addr), 0);
    send(1, 0, 5, 0, 1, 1, 1, 0);
    send(1, 0, 0, 10, 1, 1, 1, 0);
    send(1, 0, 4, 0, 0, 1, 2, 7);
    send(1, 0, 2, 3, 1, 1, 0, 4);
    send(1, 1, 6, 0, 1, 1, 1, 0);
    idle();
    idle();
    check("ill.count", 32'(word_count), 1);
    do_start();
    send(1, 0, 0, 2, 1, 2, 3, 0);
    send(1, 0, 0, 4, 4, 5, 6, 0);
    do_start();
    send(1, 0, 0, 8, 7, 8, 9, 0);
    check("restart.addr", 32'(imem_addr), 0);
    check("restart.count", 32'(word_count), 1);
    do_start();
    for (int k = 0; k < 300; k++) begin
      int cls, op, im;
      cls = $urandom_range(0, 9);
      if (cls > 7) cls = $urandom_range(0, 1);
      op = (cls <= 1) ? $urandom_range(0, 11) : (($urandom_range(0, 7) == 0) ? $urandom_range(1, 15) : 0);
      im = $urandom_range(0, 8191);
      if (cls == 4 && $urandom_range(0, 4) != 0) im = im & ~1;
      send($urandom_range(0, 3) != 0, k == 299, cls, op, $urandom_range(0, 31), $urandom_range(0, 31),
           $urandom_range(0, 31), im);
      if ($urandom_range(0, 5) == 0) idle();
    end
    idle();
    idle();
    do_start();
    send(1, 0, 0, 3, 2, 2, 2, 0);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    m_state = 0; m_count = 0; m_err = 0;
    check("rst_mid.we", 32'(imem_we), 0);
    check("rst_mid.addr", 32'(imem_addr), 0);
    check("rst_mid.ready", 32'(in_ready), 0);
    check_status("rst_mid");
    start_s = 1'b1;
    tick();
    start_s = 1'b0;
    in_last = 1'b0; op_class = 3'd0; ctrl_op = 4'd0; rd = 5'd3; rs1 = 5'd1; rs2 = 5'd2; imm = '0;
    valid_s = 1'b1;
    for (int i = 0; i < 6; i++) begin
      #1;
      check("full.ready", 32'(ready_s), 32'(i < 4));
      tick();
      check("full.we", 32'(we_s), 32'(i < 4));
      if (i < 4) begin
        check("full.addr", 32'(addr_s), 32'(4 * i));
        check("full.wdata", wdata_s, 32'h002081B3);
      end
      check("full.count", 32'(count_s), 32'(i < 4 ? i + 1 : 4));
    end
    valid_s = 1'b0;
    check("full.done", 32'(done_s), 1);
    check("full.err", 32'(err_s), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", nchk, nfail);
    $finish;
  end
endmodule
